// File: rtl/multi_lane_fifo_if.sv
// Bundle of write, read and status signals between fetch (master) and the
// multi-lane instruction queue (slave).
interface multi_lane_fifo_if #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int WR_LANES = 2,
  parameter int RD_LANES = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WC_W  = $clog2(WR_LANES + 1);
  localparam int RC_W  = $clog2(RD_LANES + 1);

  logic                         flush;
  logic [WR_LANES*DATA_W-1:0]   wr_data;
  logic [WC_W-1:0]              wr_cnt;
  logic                         wr_ready;
  logic [RD_LANES*DATA_W-1:0]   rd_data;
  logic [RD_LANES-1:0]          rd_valid;
  logic [RC_W-1:0]              rd_cnt;
  logic [CNT_W-1:0]             used_cnt;
  logic [CNT_W-1:0]             free_cnt;
  logic                         buf_empty;
  logic                         buf_full;

  modport master (
    output flush, wr_data, wr_cnt, rd_cnt,
    input  wr_ready, rd_data, rd_valid, used_cnt, free_cnt, buf_empty, buf_full
  );

  modport slave (
    input  flush, wr_data, wr_cnt, rd_cnt,
    output wr_ready, rd_data, rd_valid, used_cnt, free_cnt, buf_empty, buf_full
  );
endinterface

// File: rtl/multi_lane_fifo.sv
// Multi-lane show-ahead instruction queue: up to WR_LANES pushes and RD_LANES
// pops per cycle, in program order, with a synchronous flush for redirects.
module multi_lane_fifo #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int WR_LANES = 2,
  parameter int RD_LANES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  multi_lane_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WC_W  = $clog2(WR_LANES + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  used;
  logic [CNT_W-1:0]  free;
  logic              do_wr;
  logic [CNT_W-1:0]  acc_wr;
  logic [CNT_W-1:0]  eff_rd;
  logic [PTR_W-1:0]  wr_idx [WR_LANES];
  logic [PTR_W-1:0]  rd_idx [RD_LANES];

  // Space is judged on pre-edge occupancy only; same-cycle pops never make room.
  always_comb begin
    free         = CNT_W'(DEPTH) - used;
    bus.wr_ready = free >= CNT_W'(bus.wr_cnt);
    do_wr        = bus.wr_ready && !bus.flush && (bus.wr_cnt != '0);
    acc_wr       = do_wr ? CNT_W'(bus.wr_cnt) : '0;
    eff_rd       = (CNT_W'(bus.rd_cnt) < used) ? CNT_W'(bus.rd_cnt) : used;
  end

  always_comb begin
    for (int i = 0; i < WR_LANES; i++) begin
      wr_idx[i] = wptr + PTR_W'(i);
    end
    for (int i = 0; i < RD_LANES; i++) begin
      rd_idx[i] = rptr + PTR_W'(i);
    end
  end

  always_comb begin
    bus.rd_data  = '0;
    bus.rd_valid = '0;
    for (int i = 0; i < RD_LANES; i++) begin
      if (used > CNT_W'(i)) begin
        bus.rd_valid[i]                 = 1'b1;
        bus.rd_data[i*DATA_W +: DATA_W] = mem[rd_idx[i]];
      end
    end
  end

  assign bus.used_cnt  = used;
  assign bus.free_cnt  = free;
  assign bus.buf_empty = (used == '0);
  assign bus.buf_full  = (used == CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int i = 0; i < WR_LANES; i++) begin
        if (WC_W'(i) < bus.wr_cnt) begin
          mem[wr_idx[i]] <= bus.wr_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      used <= '0;
    end else if (bus.flush) begin
      wptr <= '0;
      rptr <= '0;
      used <= '0;
    end else begin
      wptr <= wptr + PTR_W'(acc_wr);
      rptr <= rptr + PTR_W'(eff_rd);
      used <= used + acc_wr - eff_rd;
    end
  end
endmodule

// File: tb/tb_multi_lane_fifo.sv
// Directed self-checking bench for multi_lane_fifo with hand-computed expectations.
module tb_multi_lane_fifo;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 16;
  localparam int WR_LANES = 2;
  localparam int RD_LANES = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  multi_lane_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WR_LANES(WR_LANES), .RD_LANES(RD_LANES)) bus ();

  multi_lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WR_LANES(WR_LANES), .RD_LANES(RD_LANES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic fl, input logic [1:0] wc, input logic [63:0] wd, input logic [1:0] rc);
    bus.flush   = fl;
    bus.wr_cnt  = wc;
    bus.wr_data = wd;
    bus.rd_cnt  = rc;
  endtask

  task automatic apply_stimulus(input logic fl, input logic [1:0] wc, input logic [63:0] wd, input logic [1:0] rc);
    drive(fl, wc, wd, rc);
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, 2'd0, 64'h0, 2'd0);
    #12;
    check_output("rst_empty", 64'(bus.buf_empty), 64'd1);
    check_output("rst_full", 64'(bus.buf_full), 64'd0);
    check_output("rst_free", 64'(bus.free_cnt), 64'd16);
    check_output("rst_used", 64'(bus.used_cnt), 64'd0);
    check_output("rst_valid", 64'(bus.rd_valid), 64'd0);
    check_output("rst_data", bus.rd_data, 64'h0);
    check_output("rst_ready", 64'(bus.wr_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(1'b0, 2'd2, {32'h1, 32'h2}, 2'd0);
    check_output("t1_used", 64'(bus.used_cnt), 64'd2);
    check_output("t1_valid", 64'(bus.rd_valid), 64'b11);
    check_output("t1_data", bus.rd_data, {32'h1, 32'h2});
    check_output("t1_empty", 64'(bus.buf_empty), 64'd0);

    for (int k = 1; k < 8; k++) begin
      apply_stimulus(1'b0, 2'd2, {32'h101 + 32'(2*k), 32'h100 + 32'(2*k)}, 2'd0);
    end
    check_output("t2_full", 64'(bus.buf_full), 64'd1);
    check_output("t2_free", 64'(bus.free_cnt), 64'd0);
    check_output("t2_used", 64'(bus.used_cnt), 64'd16);
    drive(1'b0, 2'd2, {32'hDEAD, 32'hBEEF}, 2'd0);
    #1;
    check_output("t2_ready_full", 64'(bus.wr_ready), 64'd0);
    @(posedge clk);
    #1;
    check_output("t2_used_hold", 64'(bus.used_cnt), 64'd16);
    check_output("t2_data_hold", bus.rd_data, {32'h1, 32'h2});
    drive(1'b0, 2'd0, 64'h0, 2'd0);
    #1;
    check_output("t2_ready_zero", 64'(bus.wr_ready), 64'd1);

    drive(1'b0, 2'd2, {32'h201, 32'h200}, 2'd2);
    #1;
    check_output("t3_ready_rej", 64'(bus.wr_ready), 64'd0);
    @(posedge clk);
    #1;
    check_output("t3_used_14", 64'(bus.used_cnt), 64'd14);
    check_output("t3_full_0", 64'(bus.buf_full), 64'd0);
    check_output("t3_data", bus.rd_data, {32'h103, 32'h102});
    drive(1'b0, 2'd2, {32'h201, 32'h200}, 2'd0);
    #1;
    check_output("t3_ready_acc", 64'(bus.wr_ready), 64'd1);
    @(posedge clk);
    #1;
    check_output("t3_used_16", 64'(bus.used_cnt), 64'd16);
    check_output("t3_full_1", 64'(bus.buf_full), 64'd1);

    // Flush back to pointer 0, then walk both pointers up to index 15.
    apply_stimulus(1'b1, 2'd0, 64'h0, 2'd0);
    check_output("fl0_used", 64'(bus.used_cnt), 64'd0);
    for (int k = 0; k < 7; k++) begin
      apply_stimulus(1'b0, 2'd2, {32'h301 + 32'(2*k), 32'h300 + 32'(2*k)}, 2'd0);
    end
    apply_stimulus(1'b0, 2'd1, {32'h0, 32'h30E}, 2'd0);
    check_output("wr_used_15", 64'(bus.used_cnt), 64'd15);
    check_output("wr_head", bus.rd_data, {32'h301, 32'h300});
    for (int k = 0; k < 7; k++) begin
      apply_stimulus(1'b0, 2'd0, 64'h0, 2'd2);
    end
    check_output("wr_used_1", 64'(bus.used_cnt), 64'd1);
    check_output("wr_last", bus.rd_data, {32'h0, 32'h30E});
    check_output("wr_valid_1", 64'(bus.rd_valid), 64'b01);

    apply_stimulus(1'b0, 2'd0, 64'h0, 2'd2);
    check_output("t5_used", 64'(bus.used_cnt), 64'd0);
    check_output("t5_valid", 64'(bus.rd_valid), 64'd0);
    check_output("t5_data", bus.rd_data, 64'h0);
    check_output("t5_empty", 64'(bus.buf_empty), 64'd1);
    check_output("t5_free", 64'(bus.free_cnt), 64'd16);

    apply_stimulus(1'b0, 2'd2, {32'hBBBB0000, 32'hAAAA0000}, 2'd0);
    check_output("t4_data", bus.rd_data, {32'hBBBB0000, 32'hAAAA0000});
    check_output("t4_mem15", 64'(dut.mem[15]), 64'hAAAA0000);
    check_output("t4_mem0", 64'(dut.mem[0]), 64'hBBBB0000);
    apply_stimulus(1'b0, 2'd0, 64'h0, 2'd2);
    check_output("t4_empty", 64'(bus.buf_empty), 64'd1);
    check_output("t4_rptr", 64'(dut.rptr), 64'd1);

    apply_stimulus(1'b0, 2'd2, {32'hDDDD0000, 32'hCCCC0000}, 2'd0);
    check_output("t6_data_cd", bus.rd_data, {32'hDDDD0000, 32'hCCCC0000});
    apply_stimulus(1'b0, 2'd2, {32'h403, 32'h402}, 2'd0);
    apply_stimulus(1'b0, 2'd2, {32'h405, 32'h404}, 2'd0);
    apply_stimulus(1'b0, 2'd1, {32'h0, 32'h406}, 2'd0);
    check_output("t6_used_7", 64'(bus.used_cnt), 64'd7);
    apply_stimulus(1'b1, 2'd2, {32'h501, 32'h500}, 2'd1);
    check_output("t6_fl_used", 64'(bus.used_cnt), 64'd0);
    check_output("t6_fl_empty", 64'(bus.buf_empty), 64'd1);
    check_output("t6_fl_valid", 64'(bus.rd_valid), 64'd0);
    check_output("t6_fl_free", 64'(bus.free_cnt), 64'd16);
    apply_stimulus(1'b0, 2'd1, {32'h0, 32'hEEEE0000}, 2'd0);
    check_output("t6_post_used", 64'(bus.used_cnt), 64'd1);
    check_output("t6_post_data", bus.rd_data, {32'h0, 32'hEEEE0000});

    apply_stimulus(1'b0, 2'd2, {32'h601, 32'h600}, 2'd0);
    check_output("rp_used_3", 64'(bus.used_cnt), 64'd3);
    drive(1'b0, 2'd0, 64'h0, 2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rp_used", 64'(bus.used_cnt), 64'd0);
    check_output("rp_empty", 64'(bus.buf_empty), 64'd1);
    check_output("rp_valid", 64'(bus.rd_valid), 64'd0);
    check_output("rp_data", bus.rd_data, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 2'd1, {32'h0, 32'hFFFF0000}, 2'd0);
    check_output("rp_post_data", bus.rd_data, {32'h0, 32'hFFFF0000});
    check_output("rp_post_used", 64'(bus.used_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
